// File: rtl/simp_umem_pkg.sv
// simp_umem shared types and helpers.
// Read/write encoding, response bundle, byte-lane merge.
package simp_umem_pkg;

  localparam int MAX_LAT    = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } rw_e;

  typedef struct packed {
    logic                  wr;
    logic                  err;
    logic [DATA_W_DEF-1:0] rdata;
  } rsp_t;

  function automatic logic [7:0] lane_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/simp_umem_if.sv
// simp_umem request/response channels.
// master = core side, slave = memory side.
interface simp_umem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_wr;

  modport master (
    output req_valid, req_rw, req_addr,
    output req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err, rsp_wr
  );

  modport slave (
    input  req_valid, req_rw, req_addr,
    input  req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err, rsp_wr
  );

endinterface

// File: rtl/simp_rsp_fifo.sv
// Generic synchronous FIFO used as the response queue.
// Any depth >= 1; push into a full FIFO is allowed only with a pop.
module simp_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_count   = r_cnt;
  assign o_rdata   = r_mem[r_rp];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= nxt(r_wp);
      if (w_do_pop)  r_rp <= nxt(r_rp);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/simp_umem.sv
// Unified SimpRisc memory: pipelined latency, byte enables,
// range/alignment errors, credit-limited in-order responses.
module simp_umem
  import simp_umem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LAT       = 1,
  parameter int                RSP_DEPTH = LAT + 1
) (
  input  logic              clk,
  input  logic              nreset,
  simp_umem_if.slave        bus,
  output logic [DATA_W-1:0] out_data_bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH+1);
  localparam int RSP_W = DATA_W + 2;
  localparam logic [ADDR_W:0] SPAN =
    (ADDR_W+1)'(DEPTH * BYTES);

  typedef struct packed {
    logic              wr;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_w_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_live;
  logic [DATA_W-1:0] r_odb;

  logic              w_acc;
  logic              w_pop;
  logic              w_err;
  logic              w_wr_en;
  rw_e               w_rw;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_merged;
  rsp_w_t            w_new;
  rsp_w_t            w_head;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_fcnt;
  logic [LAT-1:0]    w_pv;
  rsp_w_t            w_pd [LAT];

  assign w_acc = bus.req_valid && bus.req_ready;
  assign w_pop = bus.rsp_valid && bus.rsp_ready;
  assign w_rw  = rw_e'(bus.req_rw);
  assign w_off = bus.req_addr - BASE_ADDR;
  assign w_err = (bus.req_addr < BASE_ADDR)
              || ({1'b0, w_off} >= SPAN)
              || (|w_off[OFF_W-1:0]);
  assign w_idx     = w_off[OFF_W +: IDX_W];
  assign w_rd_word = r_mem[w_idx];
  assign w_wr_en   = w_acc && (w_rw == WR) && !w_err;

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    assign w_merged[8*b +: 8] = lane_merge(
      w_rd_word[8*b +: 8],
      bus.req_wdata[8*b +: 8],
      bus.req_be[b]
    );
  end

  assign w_new.wr    = (w_rw == WR);
  assign w_new.err   = w_err;
  assign w_new.rdata = ((w_rw == RD) && !w_err)
                     ? w_rd_word : '0;

  // Array write at the accept edge; array is never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= w_merged;
  end

  // Stage 0 is the accept itself; LAT-1 registers follow,
  // so the FIFO push lands exactly LAT cycles after accept.
  assign w_pv[0] = w_acc;
  assign w_pd[0] = w_new;

  for (genvar k = 1; k < LAT; k++) begin : g_pipe
    logic   r_v;
    rsp_w_t r_d;
    // Shift valid/data one stage per cycle.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= w_pv[k-1];
        r_d <= w_pd[k-1];
      end
    end
    assign w_pv[k] = r_v;
    assign w_pd[k] = r_d;
  end

  simp_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_pv[LAT-1]),
    .i_wdata (w_pd[LAT-1]),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fcnt)
  );

  // Credits: requests in the pipeline plus queued responses.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt  <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.req_ready = r_live
                      && (r_cnt < CNT_W'(RSP_DEPTH));

  assign bus.rsp_valid = !w_empty;
  assign bus.rsp_wr    = !w_empty && w_head.wr;
  assign bus.rsp_err   = !w_empty && w_head.err;
  assign bus.rsp_rdata = w_empty ? '0 : w_head.rdata;

  // Mirror of the last good read datum handed to the core.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_odb <= '0;
    end else if (w_pop && !w_head.wr && !w_head.err) begin
      r_odb <= w_head.rdata;
    end
  end

  assign out_data_bus = r_odb;

  a_lat : assert property (@(posedge clk)
    (LAT >= 1) && (LAT <= MAX_LAT));

  a_cnt : assert property (@(posedge clk)
    disable iff (!nreset)
    (r_cnt <= CNT_W'(RSP_DEPTH)) && (r_cnt >= w_fcnt));

  a_ovf : assert property (@(posedge clk)
    disable iff (!nreset)
    !(w_pv[LAT-1] && w_full && !w_pop));

  a_stab : assert property (@(posedge clk)
    disable iff (!nreset)
    bus.rsp_valid && !bus.rsp_ready |=>
      bus.rsp_valid
      && $stable({bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}));

endmodule

// File: doc/simp_umem.md
Name: simp_umem

Overview:
- Parametrised unified data/instruction memory for the SimpRisc core. Successor to the fixed 32-bit single-cycle memory modport.
- Adds a valid/ready request channel and a valid/ready response channel.
- Adds configurable pipelined latency, byte-enable writes and address-range/alignment error reporting.
- Keeps the `out_data_bus` mirror of the last read datum.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8 and ≥16.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, number of DATA_W words; power of two.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_W/8.
- LAT, 1, accept-to-response latency in cycles; legal range 1..4.
- RSP_DEPTH, LAT+1, response FIFO depth; also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables, writes only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errored requests.
- rsp_err  out  1  range or alignment error.
- rsp_wr  out  1  response belongs to a write.
- out_data_bus  out  DATA_W  rdata of the most recent read response handshake with no error.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - req_ready=0 during reset, then 1 from the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_wr=0, out_data_bus=0.
  - Pipeline, FIFO and credit counter are cleared.
  - Memory array is NOT reset.
- Accept = req_valid && req_ready. At most one accept per cycle.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - err if req_addr < BASE_ADDR, or off ≥ DEPTH*DATA_W/8, or off[log2(DATA_W/8)-1:0] != 0.
  - index = off >> log2(DATA_W/8).
- Write:
  - Committed at the accept edge. Each byte lane i updates only if req_be[i].
  - req_be=0 is legal: no update, normal response.
  - An errored write updates nothing.
- Read:
  - Data is sampled from the array at the accept edge, so it reflects all writes accepted in earlier cycles.
  - A read accepted the cycle after a write to the same word returns the new data.
- Latency and ordering:
  - Every accepted request yields exactly one response.
  - Responses are in order.
  - The response enters the FIFO exactly LAT cycles after accept, via a LAT-stage valid/data shift pipeline.
  - With the FIFO empty and rsp_ready=1, rsp_valid rises LAT cycles after accept (LAT=1: next cycle).
- Credits:
  - outstanding = pipeline entries + FIFO entries.
  - req_ready = (outstanding < RSP_DEPTH).
  - On simultaneous accept and response pop, outstanding is unchanged.
  - No response is ever dropped. The FIFO can never overflow; this is asserted.
- Response channel:
  - rsp_* outputs come from the FIFO head and are stable while rsp_valid && !rsp_ready.
  - Pop on rsp_valid && rsp_ready.
- out_data_bus: updates on the pop of a read response with rsp_err=0; otherwise holds.
- Full backpressure: with rsp_ready held 0, exactly RSP_DEPTH requests are accepted, then req_ready=0. It returns to 1 the cycle after the first pop.
- Reset mid-operation: all in-flight and queued responses are discarded. No response is emitted after reset release for pre-reset requests.
- Assertions:
  - LAT within 1..4.
  - rsp_* stable under backpressure.
  - outstanding ≤ RSP_DEPTH.

Decomposition:
- Package simp_umem_pkg:
  - typedef rw_e {RD=0, WR=1}.
  - typedef struct rsp_t {wr, err, rdata} parametrised by width via localparam defaults.
  - Helper function for byte-lane merge.
  - Constant MAX_LAT=4.
- Sub-module simp_rsp_fifo:
  - Generic synchronous FIFO (WIDTH, DEPTH).
  - Ports: push/pop/full/empty/count; async active-low reset on nreset.
  - simp_umem instantiates it for the response queue.

Test Plan:
- Basic, LAT=1, BASE_ADDR=0: write 0xDEADBEEF at 0x10 with be=0xF, then read 0x10 → write response rsp_wr=1, err=0. Read rsp_rdata=0xDEADBEEF, one cycle after accept. out_data_bus=0xDEADBEEF.
- Byte enables: word 0x20=0x11223344, then write 0xAABBCCDD with be=0b0101, then read → 0x11BB33DD.
- Errors, DEPTH=1024, DATA_W=32:
  - Read 0x1000 → rsp_err=1, rdata=0, out_data_bus unchanged.
  - Write 0x0002 → rsp_err=1, memory unchanged.
- Backpressure, LAT=3, RSP_DEPTH=4, rsp_ready=0: issue 6 back-to-back reads → exactly 4 accepted, req_ready=0 thereafter. Raise rsp_ready → 4 in-order responses, then remaining 2 accepted. No loss.
- Throughput, LAT=2, rsp_ready=1: 16 consecutive reads of addresses 0x0..0x3C → one accept per cycle, first response 2 cycles after first accept, 16 responses in order.
- Reset mid-operation: 3 reads outstanding, assert nreset for 2 cycles → rsp_valid=0 and out_data_bus=0 immediately. No responses after release. Memory contents written before reset still read back correctly.
